// File: rtl/dds_sweep_controller_pkg.sv
// Shared widths, sweep mode encodings and controller state type for the DDS sweep block.
package dds_pkg;

  localparam int FREQ_W  = 28;
  localparam int DWELL_W = 16;
  localparam int COUNT_W = 12;

  localparam logic [1:0] SWEEP_SINGLE = 2'b00;
  localparam logic [1:0] SWEEP_LOOP   = 2'b01;
  localparam logic [1:0] SWEEP_TRI    = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DWELL = 2'b01,
    STEP  = 2'b10,
    DONE  = 2'b11
  } sweep_state_e;

  // A programmed dwell of 0 behaves as 1; the timer counts down to zero inclusive.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] dwell);
    return (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : dwell - DWELL_W'(1);
  endfunction

endpackage

// File: rtl/dds_sweep_controller_if.sv
// Configuration/control and frequency-output bundle between the register bank, sweep controller and accumulator.
interface dds_sweep_controller_if;
  import dds_pkg::*;

  logic [FREQ_W-1:0]  cfg_start_freq;
  logic [FREQ_W-1:0]  cfg_step;
  logic [COUNT_W-1:0] cfg_count;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;
  logic               start;
  logic               abort;
  logic [FREQ_W-1:0]  freq_out;
  logic               freq_valid;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] step_index;

  modport master (
    output cfg_start_freq, cfg_step, cfg_count, cfg_dwell, cfg_mode, start, abort,
    input  freq_out, freq_valid, busy, done, step_index
  );

  modport slave (
    input  cfg_start_freq, cfg_step, cfg_count, cfg_dwell, cfg_mode, start, abort,
    output freq_out, freq_valid, busy, done, step_index
  );
endinterface

// File: rtl/dds_sweep_controller_dwell_timer.sv
// Per-point dwell countdown: load a reload value, count down to zero, flag expiry (registered).
module dds_dwell_timer
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expired_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               expired_q;

  // Next count: load has priority, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {DWELL_W{1'b0}}) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and expiry flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= {DWELL_W{1'b0}};
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == {DWELL_W{1'b0}});
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/dds_sweep_controller.sv
// DDS frequency sweep sequencer: single, looping and triangle sweeps of a tuning word.
// Optional build macro DDS_SWEEP_EXT_TRIG_EN replaces the dwell timer with an external step_trig edge.
module dds_sweep_controller
  import dds_pkg::*;
(
  input logic clk,
  input logic rst_n,
`ifdef DDS_SWEEP_EXT_TRIG_EN
  input logic step_trig,
`endif
  dds_sweep_controller_if.slave bus
);

  sweep_state_e       state_q, state_d;
  logic [FREQ_W-1:0]  start_freq_q, start_freq_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_up_q, dir_up_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               step_now_s;

`ifdef DDS_SWEEP_EXT_TRIG_EN
  logic trig_q;

  // Registered copy of step_trig for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= step_trig;
    end
  end

  assign step_now_s = step_trig & ~trig_q;
`else
  logic               load_s;
  logic [DWELL_W-1:0] load_val_s;

  // On start the latches are not yet valid, so reload from the live config.
  assign load_s     = (state_d == DWELL) && (state_q != DWELL);
  assign load_val_s = (state_q == IDLE) ? dwell_reload(bus.cfg_dwell) : dwell_reload(dwell_q);

  dds_dwell_timer u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .expired_o  (step_now_s)
  );
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    start_freq_d = start_freq_q;
    step_d       = step_q;
    count_d      = count_q;
    dwell_d      = dwell_q;
    mode_d       = mode_q;
    dir_up_d     = dir_up_q;
    freq_d       = freq_q;
    idx_d        = idx_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          start_freq_d = bus.cfg_start_freq;
          step_d       = bus.cfg_step;
          count_d      = bus.cfg_count;
          dwell_d      = bus.cfg_dwell;
          mode_d       = bus.cfg_mode;
          dir_up_d     = 1'b1;
          freq_d       = bus.cfg_start_freq;
          idx_d        = {COUNT_W{1'b0}};
          valid_d      = 1'b1;
          state_d      = DWELL;
        end else begin
          state_d = IDLE;
        end
      end
      DWELL: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (step_now_s) begin
          state_d = STEP;
        end else begin
          state_d = DWELL;
        end
      end
      STEP: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DWELL;
          valid_d = 1'b1;
          if (dir_up_q && (idx_q < count_q)) begin
            freq_d = freq_q + step_q;
            idx_d  = idx_q + COUNT_W'(1);
          end else if (!dir_up_q && (idx_q != {COUNT_W{1'b0}})) begin
            freq_d = freq_q - step_q;
            idx_d  = idx_q - COUNT_W'(1);
          end else begin
            // At an end of the range; count==0 triangle simply reissues the point.
            case (mode_q)
              SWEEP_LOOP: begin
                freq_d = start_freq_q;
                idx_d  = {COUNT_W{1'b0}};
              end
              SWEEP_TRI: begin
                if (count_q == {COUNT_W{1'b0}}) begin
                  freq_d = freq_q;
                end else if (dir_up_q) begin
                  dir_up_d = 1'b0;
                  freq_d   = freq_q - step_q;
                  idx_d    = idx_q - COUNT_W'(1);
                end else begin
                  dir_up_d = 1'b1;
                  freq_d   = freq_q + step_q;
                  idx_d    = idx_q + COUNT_W'(1);
                end
              end
              default: begin
                state_d = DONE;
                valid_d = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = bus.abort;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DWELL) || (state_d == STEP);
  end

  // State, configuration latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_freq_q <= {FREQ_W{1'b0}};
      step_q       <= {FREQ_W{1'b0}};
      count_q      <= {COUNT_W{1'b0}};
      dwell_q      <= {DWELL_W{1'b0}};
      mode_q       <= 2'b00;
      dir_up_q     <= 1'b1;
      freq_q       <= {FREQ_W{1'b0}};
      idx_q        <= {COUNT_W{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_freq_q <= start_freq_d;
      step_q       <= step_d;
      count_q      <= count_d;
      dwell_q      <= dwell_d;
      mode_q       <= mode_d;
      dir_up_q     <= dir_up_d;
      freq_q       <= freq_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.freq_out   = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_index = idx_q;

endmodule

// File: doc/dds_sweep_controller.md
Name: dds_sweep_controller

Overview:
- Frequency sweep sequencer for the DDS core. Sits between the SPI register bank and the phase accumulator, downstream of the frequency tuning register.
- Latches a sweep configuration on a start pulse, then steps a 28-bit tuning word by a programmable increment at a programmable dwell rate.
- Supports single, continuous and triangle sweeps. Emits a validated frequency word for the accumulator to load.

Parameters:
- FREQ_W, 28, tuning word width (matches the phase accumulator)
- DWELL_W, 16, dwell counter width in clk cycles
- COUNT_W, 12, step counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_start_freq  in  FREQ_W  first tuning word of the sweep
- cfg_step  in  FREQ_W  increment per step, unsigned
- cfg_count  in  COUNT_W  number of steps after the start point
- cfg_dwell  in  DWELL_W  clk cycles held per point; 0 is treated as 1
- cfg_mode  in  2  00 single-up, 01 continuous-up, 10 continuous triangle, 11 same as 00
- start  in  1  one-cycle pulse, begins a sweep
- abort  in  1  one-cycle pulse, stops the sweep
- freq_out  out  FREQ_W  current tuning word
- freq_valid  out  1  one-cycle pulse whenever freq_out takes a new value
- busy  out  1  high from the cycle after start until the sweep ends
- done  out  1  one-cycle pulse at end of a single-up sweep or on abort
- step_index  out  COUNT_W  current point index, 0..cfg_count

Behaviour:
- Reset: all outputs 0; state IDLE; internal config latches cleared.
- States and transitions:
  - IDLE: start=1 (and abort=0) latches all cfg_* inputs. Next cycle: freq_out=cfg_start_freq, step_index=0, freq_valid=1, busy=1, state DWELL, dwell counter loaded with max(cfg_dwell,1)-1. Config changes after start are ignored until the next start.
  - DWELL: decrements the dwell counter. At 0, go to STEP.
  - STEP, one cycle, computes the next point:
    - Going up with step_index<count: freq_out += step, step_index+1.
    - Going down with step_index>0: freq_out -= step, step_index-1.
    - freq_valid is pulsed in the cycle freq_out changes. Then reload dwell and return to DWELL.
  - End of range, mode 00/11: at step_index==count, go to DONE with no new point.
  - End of range, mode 01: restart at cfg_start_freq with index 0; freq_valid pulses.
  - End of range, mode 10: reverse direction at index==count (going up) or index==0 (going down). The first new point after reversal is one step inward, so the end value is never repeated.
  - DONE: done=1 for one cycle, busy=0, freq_out holds its last value, then IDLE.
- Arithmetic: add/subtract is modulo 2^FREQ_W; wrap-around is allowed and not flagged.
- Boundary rules:
  - Point timing: each point is held for exactly max(cfg_dwell,1)+1 cycles (dwell plus the STEP cycle).
  - cfg_count=0: mode 00 emits a single point, then DONE after one dwell. Modes 01 and 10 reissue the same point every dwell with a freq_valid pulse.
  - start while busy is ignored.
  - abort in any non-IDLE state: next cycle state is IDLE, busy=0, done=1, freq_out holds. abort in IDLE has no effect.
  - start and abort in the same cycle: abort wins; from IDLE nothing happens.
  - rst_n low mid-sweep: everything returns to reset values on the next clk edge.

Optional Feature:
- Macro: DDS_SWEEP_EXT_TRIG_EN.
- When defined:
  - Adds input step_trig (1 bit, synchronous to clk).
  - A rising edge on step_trig, detected against a registered copy, replaces dwell expiry as the only cause of DWELL->STEP.
  - cfg_dwell is ignored.
  - An edge in the same cycle the sweep starts is not counted.
- When undefined: no step_trig port; internal dwell timer only.

Decomposition:
- Shared package dds_pkg holds:
  - Width constants FREQ_W, DWELL_W, COUNT_W.
  - Mode encodings SWEEP_SINGLE=2'b00, SWEEP_LOOP=2'b01, SWEEP_TRI=2'b10.
  - State enum IDLE/DWELL/STEP/DONE.
- One natural sub-module: dds_dwell_timer (load value, decrement, expire pulse). It is bypassed by the trigger edge detector under DDS_SWEEP_EXT_TRIG_EN.

Test Plan:
- Single sweep: start=0x0001000, step=0x0000100, count=3, dwell=4, mode 00 -> freq_out 0x0001000, 0x0001100, 0x0001200, 0x0001300, each 5 cycles apart; freq_valid 4 pulses; done pulses 5 cycles after the last point; busy drops with done.
- Wrap: start=0xFFFFF80, step=0x100, count=1, mode 00 -> second point 0x0000080, no error.
- Triangle: count=2, step=0x10, start=0, dwell=1, mode 10 -> freq_out 0, 0x10, 0x20, 0x10, 0, 0x10, ... with no duplicated endpoints; busy stays high.
- Abort: abort asserted at the 2nd DWELL cycle of point 1 -> next cycle busy=0, done=1, freq_out unchanged; a later start with new cfg restarts from the new start_freq.
- Corner cases:
  - dwell=0 behaves as dwell=1.
  - start while busy is ignored.
  - start+abort in IDLE gives no activity.
  - rst_n low mid-sweep zeroes all outputs on the next edge.
- With DDS_SWEEP_EXT_TRIG_EN: dwell=100, step_trig toggled every 3 cycles -> a new point follows each trig rising edge, independent of dwell.
